// File: rtl/qspi_flash_rd_ctrl_if.sv
// rtl/qspi_flash_rd_ctrl_if.sv - word-read request/response handshake between requester and QSPI read controller
//
// Signals:
//   rd_req   requester -> ctrl  read request, held until accepted
//   rd_addr  requester -> ctrl  byte address, [1:0] ignored
//   rd_ready ctrl -> requester  controller idle, request will be taken
//   rd_valid ctrl -> requester  one-cycle pulse, rd_data valid
//   rd_data  ctrl -> requester  little-endian read word
interface qspi_flash_rd_ctrl_if;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ready,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/qspi_flash_rd_ctrl.sv
// rtl/qspi_flash_rd_ctrl.sv - 0xEB fast-read-quad-I/O sequencer returning one 32-bit word per request
//
// Ports:
//   HCLK, HRESETn   system clock, asynchronous active-low reset
//   rd              request/response handshake (slave side)
//   fdi[3:0]        flash SIO sampled
//   fdo[3:0]        flash SIO driven
//   fdoe            output enable for all SIO lines
//   fsclk           flash serial clock, HCLK/2 while a transaction runs
//   fcen            flash chip enable, active-low
module qspi_flash_rd_ctrl #(
    parameter int DUMMY   = 4,
    parameter int CS_HIGH = 2
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    qspi_flash_rd_ctrl_if.slave        rd,
    input  logic [3:0]                 fdi,
    output logic [3:0]                 fdo,
    output logic                       fdoe,
    output logic                       fsclk,
    output logic                       fcen
);

    localparam logic [7:0] CMD_OP = 8'hEB;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_DONE, S_GAP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;        // SCK bit index within the current state
    logic        phase_h;    // 0: phase L (fsclk low), 1: phase H (fsclk high)
    logic [23:0] addr_q;
    logic [31:0] data_sr;
    logic [3:0]  gap_cnt;
    logic        rd_valid_q;
    logic [31:0] rd_data_q;

    logic [3:0]  last_cnt;
    logic        bit_last;
    state_t      nxt_state;
    logic [3:0]  nxt_cnt;
    logic [31:0] data_ins;

    assign rd.rd_ready = (state == S_IDLE);
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_data  = rd_data_q;

    // Pin values {fdoe, fdo} for the SCK bit (st, c); driven for the whole bit.
    function automatic logic [4:0] bit_drive(input state_t st, input logic [3:0] c,
                                             input logic [23:0] a);
        logic [4:0] d;
        d = 5'b0_0000;
        case (st)
            S_CMD:  d = {1'b1, 3'b111, CMD_OP[~c[2:0]]};
            S_ADDR: begin
                case (c)
                    4'd0:    d = {1'b1, a[23:20]};
                    4'd1:    d = {1'b1, a[19:16]};
                    4'd2:    d = {1'b1, a[15:12]};
                    4'd3:    d = {1'b1, a[11:8]};
                    4'd4:    d = {1'b1, a[7:4]};
                    default: d = {1'b1, a[3:0]};
                endcase
            end
            S_MODE:  d = 5'b1_0000;
            default: d = 5'b0_0000;
        endcase
        return d;
    endfunction

    always_comb begin
        case (state)
            S_CMD:   last_cnt = 4'd7;
            S_ADDR:  last_cnt = 4'd5;
            S_MODE:  last_cnt = 4'd1;
            S_DUMMY: last_cnt = 4'(DUMMY - 1);
            default: last_cnt = 4'd7;
        endcase
    end

    assign bit_last = (cnt == last_cnt);

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 4'd1;
        if (bit_last) begin
            nxt_cnt = 4'd0;
            case (state)
                S_CMD:   nxt_state = S_ADDR;
                S_ADDR:  nxt_state = S_MODE;
                S_MODE:  nxt_state = S_DUMMY;
                S_DUMMY: nxt_state = S_DATA;
                default: nxt_state = S_DONE;
            endcase
        end
    end

    // Nibble k lands in byte k/2; even k is the high nibble.
    always_comb begin
        data_ins = data_sr;
        data_ins[{cnt[2:1], ~cnt[0], 2'b00} +: 4] = fdi;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            phase_h    <= 1'b0;
            addr_q     <= 24'h0;
            data_sr    <= 32'h0;
            gap_cnt    <= 4'd0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'h0;
            fdo        <= 4'h0;
            fdoe       <= 1'b0;
            fsclk      <= 1'b0;
            fcen       <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd.rd_req) begin
                        state         <= S_CMD;
                        cnt           <= 4'd0;
                        phase_h       <= 1'b0;
                        addr_q        <= rd.rd_addr & 24'hFF_FFFC;
                        fcen          <= 1'b0;
                        fsclk         <= 1'b0;
                        {fdoe, fdo}   <= bit_drive(S_CMD, 4'd0, addr_q);
                    end
                end
                S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA: begin
                    if (!phase_h) begin
                        fsclk   <= 1'b1;
                        phase_h <= 1'b1;
                    end else begin
                        // End of phase H: fdi is sampled here, next bit starts in phase L.
                        fsclk       <= 1'b0;
                        phase_h     <= 1'b0;
                        state       <= nxt_state;
                        cnt         <= nxt_cnt;
                        {fdoe, fdo} <= bit_drive(nxt_state, nxt_cnt, addr_q);
                        if (state == S_DATA) begin
                            data_sr <= data_ins;
                        end
                        if (nxt_state == S_DONE) begin
                            fcen       <= 1'b1;
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= data_ins;
                        end
                    end
                end
                S_DONE: begin
                    gap_cnt <= 4'(CS_HIGH - 1);
                    state   <= (CS_HIGH > 1) ? S_GAP : S_IDLE;
                end
                S_GAP: begin
                    if (gap_cnt <= 4'd1) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_flash_rd_ctrl.sv
// tb/tb_qspi_flash_rd_ctrl.sv - self-checking bench for qspi_flash_rd_ctrl with a quad-SPI flash model
module tb_qspi_flash_rd_ctrl;

    logic clk;
    logic rst_n;

    logic [1:0]  req_v;
    logic [23:0] addr_v [2];
    logic [1:0]  ready_v;
    logic [1:0]  valid_v;
    logic [31:0] data_v [2];

    logic [3:0]  fdi_v [2];
    logic [3:0]  fdo_v [2];
    logic [1:0]  fdoe_v;
    logic [1:0]  fsclk_v;
    logic [1:0]  fcen_v;

    qspi_flash_rd_ctrl_if rd0 ();
    qspi_flash_rd_ctrl_if rd1 ();

    assign rd0.rd_req  = req_v[0];
    assign rd0.rd_addr = addr_v[0];
    assign rd1.rd_req  = req_v[1];
    assign rd1.rd_addr = addr_v[1];
    assign ready_v     = {rd1.rd_ready, rd0.rd_ready};
    assign valid_v     = {rd1.rd_valid, rd0.rd_valid};
    assign data_v[0]   = rd0.rd_data;
    assign data_v[1]   = rd1.rd_data;

    qspi_flash_rd_ctrl #(.DUMMY(4), .CS_HIGH(2)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .rd(rd0),
        .fdi(fdi_v[0]), .fdo(fdo_v[0]), .fdoe(fdoe_v[0]), .fsclk(fsclk_v[0]), .fcen(fcen_v[0])
    );

    qspi_flash_rd_ctrl #(.DUMMY(6), .CS_HIGH(2)) dut1 (
        .HCLK(clk), .HRESETn(rst_n), .rd(rd1),
        .fdi(fdi_v[1]), .fdo(fdo_v[1]), .fdoe(fdoe_v[1]), .fsclk(fsclk_v[1]), .fcen(fcen_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Flash model: one per instance, sampled mid-cycle on negedge.
    logic [7:0]  mem [512];
    int          k      [2] = '{0, 0};
    int          k_last [2] = '{0, 0};
    logic [7:0]  op_cap [2];
    logic [23:0] addr_cap [2];
    logic [31:0] oe_hist [2];
    logic [1:0]  fcen_p  = 2'b11;
    logic [1:0]  fsclk_p = 2'b00;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int j;
            logic [7:0] b;
            int dm;
            dm = (g == 0) ? 4 : 6;
            if (fcen_v[g]) begin
                if (!fcen_p[g]) k_last[g] = k[g];
                k[g]     = 0;
                fdi_v[g] = 4'h0;
            end else begin
                if (fcen_p[g]) begin
                    op_cap[g]   = 8'h0;
                    addr_cap[g] = 24'h0;
                    oe_hist[g]  = 32'h0;
                end
                if (fsclk_v[g] && !fsclk_p[g]) begin
                    k[g] = k[g] + 1;
                    oe_hist[g] = {oe_hist[g][30:0], fdoe_v[g]};
                    if (k[g] <= 8) op_cap[g] = {op_cap[g][6:0], fdo_v[g][0]};
                    else if (k[g] <= 14) addr_cap[g] = {addr_cap[g][19:0], fdo_v[g]};
                    j = k[g] - (17 + dm);
                    if (j >= 0 && j < 8) begin
                        b = mem[9'(addr_cap[g][8:0] + 9'(j / 2))];
                        fdi_v[g] = (j % 2 == 1) ? b[3:0] : b[7:4];
                    end
                end
            end
            fcen_p[g]  = fcen_v[g];
            fsclk_p[g] = fsclk_v[g];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_read(input int g, input logic [23:0] a, input logic [31:0] ed,
                           input logic [23:0] eb, input int el);
        int c;
        int lowc;
        int sclk_bad;
        int sck;
        sck = (el - 1) / 2;
        @(negedge clk);
        chk("ready_idle", 32'(ready_v[g]), 1);
        addr_v[g] = a;
        req_v[g]  = 1'b1;
        @(negedge clk);
        req_v[g]  = 1'b0;
        chk("ready_busy", 32'(ready_v[g]), 0);
        c = 1; lowc = 0; sclk_bad = 0;
        while (c < 200) begin
            if (valid_v[g]) break;
            if (!fcen_v[g]) lowc++;
            if (fcen_v[g] && fsclk_v[g]) sclk_bad++;
            @(negedge clk);
            c++;
        end
        #1;
        chk("latency", c, el);
        chk("data", data_v[g], ed);
        chk("fcen_low_cycles", lowc, el - 1);
        chk("sclk_while_cs_high", sclk_bad, 0);
        chk("cmd_opcode", 32'(op_cap[g]), 32'hEB);
        chk("bus_addr", 32'(addr_cap[g]), 32'(eb));
        chk("sck_edges", k_last[g], sck);
        chk("oe_pattern", oe_hist[g] & ((32'h1 << sck) - 32'h1), 32'hFFFF << (sck - 16));
        @(negedge clk);
        chk("valid_pulse", 32'(valid_v[g]), 0);
        chk("data_hold", data_v[g], ed);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [31:0] data;
        logic [23:0] bus;
    } vec_t;

    vec_t vt [4];
    logic [23:0] b2b_addr [3];
    logic [31:0] b2b_exp  [3];

    initial begin
        int acc [3];
        int na, nv, hi, min_hi;
        bit pend;

        for (int i = 0; i < 512; i++) begin
            logic [8:0] ix;
            ix = 9'(i);
            mem[i] = 8'(ix[7:0] + 8'h10) ^ {ix[8], 7'b0};
        end
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'hA0; mem[3] = 8'hFF;

        vt[0] = '{24'h000000, 32'hFFA00513, 24'h000000};
        vt[1] = '{24'h000106, 32'h97969594, 24'h000104};
        vt[2] = '{24'h0001FF, 32'h8F8E8D8C, 24'h0001FC};
        vt[3] = '{24'h000009, 32'h1B1A1918, 24'h000008};
        b2b_addr = '{24'h000000, 24'h000004, 24'h000008};
        b2b_exp  = '{32'hFFA00513, 32'h17161514, 32'h1B1A1918};

        req_v = 2'b00; addr_v[0] = 24'h0; addr_v[1] = 24'h0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(ready_v[0]), 1);
        chk("rst_valid", 32'(valid_v[0]), 0);
        chk("rst_data", data_v[0], 0);
        chk("rst_fcen", 32'(fcen_v[0]), 1);
        chk("rst_fsclk", 32'(fsclk_v[0]), 0);
        chk("rst_fdoe", 32'(fdoe_v[0]), 0);
        chk("rst_fdo", 32'(fdo_v[0]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            do_read(0, vt[i].addr, vt[i].data, vt[i].bus, 57);
        end

        // Back-to-back reads with rd_req held high.
        @(negedge clk);
        chk("b2b_ready", 32'(ready_v[0]), 1);
        req_v[0] = 1'b1; addr_v[0] = b2b_addr[0];
        acc[0] = 0; na = 1; pend = 1'b1; nv = 0; hi = 0; min_hi = 99;
        for (int n = 1; n < 400 && nv < 3; n++) begin
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                if (na < 3) addr_v[0] = b2b_addr[na];
                else req_v[0] = 1'b0;
            end
            if (valid_v[0]) begin
                if (nv < 3) chk("b2b_data", data_v[0], b2b_exp[nv]);
                nv++;
            end
            if (fcen_v[0]) hi++;
            else begin
                if (hi > 0 && hi < min_hi) min_hi = hi;
                hi = 0;
            end
            if (ready_v[0] && req_v[0]) begin
                if (na < 3) acc[na] = n;
                na++;
                pend = 1'b1;
            end
        end
        req_v[0] = 1'b0;
        chk("b2b_valid_count", nv, 3);
        chk("b2b_accept_count", na, 3);
        chk("b2b_spacing_1", acc[1] - acc[0], 59);
        chk("b2b_spacing_2", acc[2] - acc[1], 59);
        chk("b2b_cs_high_min", 32'(min_hi >= 2), 1);
        repeat (3) @(negedge clk);

        // Reset during DATA.
        @(negedge clk);
        addr_v[0] = 24'h000104; req_v[0] = 1'b1;
        @(negedge clk);
        req_v[0] = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_fcen", 32'(fcen_v[0]), 1);
        chk("midrst_fdoe", 32'(fdoe_v[0]), 0);
        chk("midrst_fsclk", 32'(fsclk_v[0]), 0);
        chk("midrst_valid", 32'(valid_v[0]), 0);
        chk("midrst_ready", 32'(ready_v[0]), 1);
        chk("midrst_data", data_v[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_read(0, 24'h000104, 32'h97969594, 24'h000104, 57);

        // DUMMY=6 instance.
        do_read(1, 24'h000000, 32'hFFA00513, 24'h000000, 61);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
